// File: rtl/password_lock_if.sv
// Signal bundle between the key pad controller and the password gate.
interface password_lock_if;
   logic       on;
   logic       en_key;
   logic [3:0] key;
   logic       lock;
   logic       pw_change;
   logic       o_unlock;
   logic       o_locked_out;
   logic       o_fail;
   logic [2:0] digit_count;
   logic [1:0] tries_left;
   logic [2:0] state_out;

   modport master (
      output on, en_key, key, lock, pw_change,
      input  o_unlock, o_locked_out, o_fail, digit_count, tries_left, state_out
   );

   modport slave (
      input  on, en_key, key, lock, pw_change,
      output o_unlock, o_locked_out, o_fail, digit_count, tries_left, state_out
   );
endinterface

// File: rtl/password_lock.sv
// Password gate ahead of the address/data entry stage: collects key digits,
// checks them against a stored password, counts failures and enforces lockout.
module password_lock #(
   parameter int                  PW_LEN         = 4,
   parameter logic [4*PW_LEN-1:0] PW_DEFAULT     = 16'h1234,
   parameter int                  MAX_TRIES      = 3,
   parameter int                  LOCK_CYCLES    = 50000000,
   parameter int                  TIMEOUT_CYCLES = 250000000
) (
   input  logic           clk,
   input  logic           rst,
   password_lock_if.slave bus
);
   localparam int PW_W   = 4 * PW_LEN;
   localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   localparam logic [2:0]        LAST_DIGIT = 3'(PW_LEN - 1);
   localparam logic [1:0]        TRIES_INIT = 2'(MAX_TRIES);
   localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_ENTRY    = 3'd0,
      ST_CHECK    = 3'd1,
      ST_UNLOCKED = 3'd2,
      ST_CHANGE   = 3'd3,
      ST_LOCKOUT  = 3'd4
   } state_t;

   state_t            state, state_nx;
   logic [PW_W-1:0]   pw, pw_nx;
   logic [PW_W-1:0]   entry, entry_nx;
   logic [PW_W-1:0]   shadow, shadow_nx;
   logic [PW_W-1:0]   entry_shift, shadow_shift;
   logic [2:0]        count, count_nx;
   logic [1:0]        tries, tries_nx;
   logic [IDLE_W-1:0] idle, idle_nx;
   logic [LOCK_W-1:0] lock_cnt, lock_cnt_nx;
   logic              fail, fail_nx;

   // New digit enters at the LSBs so the first digit ends up in the MSBs.
   generate
      if (PW_LEN > 1) begin : g_shift_multi
         assign entry_shift  = {entry[PW_W-5:0], bus.key};
         assign shadow_shift = {shadow[PW_W-5:0], bus.key};
      end else begin : g_shift_single
         assign entry_shift  = bus.key;
         assign shadow_shift = bus.key;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_ENTRY;
         pw       <= PW_DEFAULT;
         entry    <= '0;
         shadow   <= '0;
         count    <= '0;
         tries    <= TRIES_INIT;
         idle     <= '0;
         lock_cnt <= '0;
         fail     <= 1'b0;
      end else begin
         state    <= state_nx;
         pw       <= pw_nx;
         entry    <= entry_nx;
         shadow   <= shadow_nx;
         count    <= count_nx;
         tries    <= tries_nx;
         idle     <= idle_nx;
         lock_cnt <= lock_cnt_nx;
         fail     <= fail_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      pw_nx       = pw;
      entry_nx    = entry;
      shadow_nx   = shadow;
      count_nx    = count;
      tries_nx    = tries;
      idle_nx     = idle;
      lock_cnt_nx = lock_cnt;
      fail_nx     = 1'b0;

      if (state == ST_LOCKOUT) begin
         // Lockout runs to completion regardless of on/lock.
         if (lock_cnt == LOCK_LAST) begin
            state_nx    = ST_ENTRY;
            tries_nx    = TRIES_INIT;
            lock_cnt_nx = '0;
         end else begin
            lock_cnt_nx = lock_cnt + 1'b1;
         end
      end else if (!bus.on) begin
         state_nx = ST_ENTRY;
         entry_nx = '0;
         count_nx = '0;
         idle_nx  = '0;
      end else begin
         case (state)
            ST_ENTRY: begin
               if (bus.en_key) begin
                  entry_nx = entry_shift;
                  idle_nx  = '0;
                  if (count == LAST_DIGIT) begin
                     state_nx = ST_CHECK;
                     count_nx = '0;
                  end else begin
                     count_nx = count + 3'd1;
                  end
               end else if (count != 3'd0) begin
                  // A stalled partial entry is silently discarded.
                  if (idle == IDLE_LAST) begin
                     entry_nx = '0;
                     count_nx = '0;
                     idle_nx  = '0;
                  end else begin
                     idle_nx = idle + 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               entry_nx = '0;
               if (entry == pw) begin
                  state_nx = ST_UNLOCKED;
                  tries_nx = TRIES_INIT;
               end else begin
                  fail_nx  = 1'b1;
                  tries_nx = (tries != 2'd0) ? tries - 2'd1 : 2'd0;
                  if (tries <= 2'd1) begin
                     state_nx    = ST_LOCKOUT;
                     lock_cnt_nx = '0;
                  end else begin
                     state_nx = ST_ENTRY;
                  end
               end
            end
            ST_UNLOCKED: begin
               if (bus.lock) begin
                  state_nx = ST_ENTRY;
               end else if (bus.pw_change) begin
                  state_nx  = ST_CHANGE;
                  count_nx  = '0;
                  shadow_nx = '0;
               end
            end
            ST_CHANGE: begin
               if (bus.lock) begin
                  state_nx = ST_ENTRY;
                  count_nx = '0;
               end else if (bus.en_key) begin
                  shadow_nx = shadow_shift;
                  if (count == LAST_DIGIT) begin
                     pw_nx    = shadow_shift;
                     state_nx = ST_UNLOCKED;
                     count_nx = '0;
                  end else begin
                     count_nx = count + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_unlock     = (state == ST_UNLOCKED) || (state == ST_CHANGE);
   assign bus.o_locked_out = (state == ST_LOCKOUT);
   assign bus.o_fail       = fail;
   assign bus.digit_count  = count;
   assign bus.tries_left   = tries;
   assign bus.state_out    = state;
endmodule

// File: tb/tb_password_lock.sv
// Bench for password_lock: directed scenarios plus random traffic, all outputs
// compared every cycle against a digit-queue model of the lock's rules.
module tb_password_lock;
   localparam int              PW_LEN         = 4;
   localparam logic [15:0]     PW_DEFAULT     = 16'h1234;
   localparam int              MAX_TRIES      = 3;
   localparam int              LOCK_CYCLES    = 20;
   localparam int              TIMEOUT_CYCLES = 100;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   password_lock_if bus ();

   password_lock #(
      .PW_LEN(PW_LEN), .PW_DEFAULT(PW_DEFAULT), .MAX_TRIES(MAX_TRIES),
      .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: 0=ENTRY 1=CHECK 2=UNLOCKED 3=CHANGE 4=LOCKOUT
   int m_state;
   int m_entry[$];
   int m_new[$];
   int m_pw[$];
   int m_tries;
   int m_idle;
   int m_lock_rem;
   int m_fail;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_entry.delete();
      m_new.delete();
      m_pw.delete();
      for (int i = 0; i < PW_LEN; i++)
         m_pw.push_back(int'((PW_DEFAULT >> (4 * (PW_LEN - 1 - i))) & 16'hF));
      m_tries    = MAX_TRIES;
      m_idle     = 0;
      m_lock_rem = 0;
      m_fail     = 0;
   endtask

   task automatic model_step();
      int ok;
      m_fail = 0;
      if (m_state == 4) begin
         m_lock_rem--;
         if (m_lock_rem == 0) begin
            m_state = 0;
            m_tries = MAX_TRIES;
         end
      end else if (!bus.on) begin
         m_state = 0;
         m_entry.delete();
         m_new.delete();
         m_idle = 0;
      end else begin
         case (m_state)
            0: begin
               if (bus.en_key) begin
                  m_entry.push_back(int'(bus.key));
                  m_idle = 0;
                  if (m_entry.size() == PW_LEN) m_state = 1;
               end else if (m_entry.size() > 0) begin
                  m_idle++;
                  if (m_idle == TIMEOUT_CYCLES) begin
                     m_entry.delete();
                     m_idle = 0;
                  end
               end
            end
            1: begin
               ok = 1;
               for (int i = 0; i < PW_LEN; i++)
                  if (m_entry[i] != m_pw[i]) ok = 0;
               m_entry.delete();
               if (ok == 1) begin
                  m_state = 2;
                  m_tries = MAX_TRIES;
               end else begin
                  m_fail = 1;
                  if (m_tries > 0) m_tries--;
                  if (m_tries == 0) begin
                     m_state    = 4;
                     m_lock_rem = LOCK_CYCLES;
                  end else begin
                     m_state = 0;
                  end
               end
            end
            2: begin
               if (bus.lock) m_state = 0;
               else if (bus.pw_change) begin
                  m_state = 3;
                  m_new.delete();
               end
            end
            3: begin
               if (bus.lock) begin
                  m_state = 0;
                  m_new.delete();
               end else if (bus.en_key) begin
                  m_new.push_back(int'(bus.key));
                  if (m_new.size() == PW_LEN) begin
                     m_pw = m_new;
                     m_new.delete();
                     m_state = 2;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else model_step();
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         check("state_out", int'(bus.state_out), m_state);
         check("o_unlock", int'(bus.o_unlock), (m_state == 2 || m_state == 3) ? 1 : 0);
         check("o_locked_out", int'(bus.o_locked_out), (m_state == 4) ? 1 : 0);
         check("o_fail", int'(bus.o_fail), m_fail);
         check("tries_left", int'(bus.tries_left), m_tries);
         check("digit_count", int'(bus.digit_count),
               (m_state == 0) ? m_entry.size() : ((m_state == 3) ? m_new.size() : 0));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic press(input int d);
      bus.key    = 4'(d);
      bus.en_key = 1'b1;
      @(negedge clk);
      bus.en_key = 1'b0;
   endtask

   task automatic enter4(input int a, input int b, input int c, input int d);
      press(a); @(negedge clk);
      press(b); @(negedge clk);
      press(c); @(negedge clk);
      press(d);
   endtask

   task automatic pulse_lock();
      bus.lock = 1'b1;
      @(negedge clk);
      bus.lock = 1'b0;
   endtask

   task automatic pulse_change();
      bus.pw_change = 1'b1;
      @(negedge clk);
      bus.pw_change = 1'b0;
   endtask

   initial begin
      int n;
      int rate;
      int idx;
      rst           = 1'b0;
      bus.on        = 1'b0;
      bus.en_key    = 1'b0;
      bus.key       = 4'd0;
      bus.lock      = 1'b0;
      bus.pw_change = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", int'(bus.state_out), 0);
      check("rst_tries", int'(bus.tries_left), 3);
      check("rst_unlock", int'(bus.o_unlock), 0);
      rst    = 1'b1;
      bus.on = 1'b1;
      @(negedge clk);

      // Correct entry unlocks two edges after the last strobe
      enter4(1, 2, 3, 4);
      check("in_check_state", int'(bus.state_out), 1);
      check("in_check_unlock", int'(bus.o_unlock), 0);
      @(negedge clk);
      check("unlock_after_2", int'(bus.o_unlock), 1);
      check("unlock_state", int'(bus.state_out), 2);
      pulse_lock();
      check("relock", int'(bus.o_unlock), 0);

      // Three wrong entries lead to lockout
      enter4(1, 2, 3, 5); @(negedge clk);
      check("fail1_pulse", int'(bus.o_fail), 1);
      check("fail1_tries", int'(bus.tries_left), 2);
      enter4(1, 2, 3, 5); @(negedge clk);
      check("fail2_tries", int'(bus.tries_left), 1);
      enter4(1, 2, 3, 5); @(negedge clk);
      check("lockout_on", int'(bus.o_locked_out), 1);
      check("lockout_tries", int'(bus.tries_left), 0);
      n = 0;
      while (bus.o_locked_out && n < 100) begin
         n++;
         bus.key    = 4'd1;
         bus.en_key = n[0];
         bus.on     = (n != 7);
         @(negedge clk);
      end
      bus.en_key = 1'b0;
      bus.on     = 1'b1;
      check("lockout_len", n, LOCK_CYCLES);
      check("lockout_tries_back", int'(bus.tries_left), 3);

      // Two failures, then success restores tries
      enter4(5, 5, 5, 5); @(negedge clk);
      enter4(4, 3, 2, 1); @(negedge clk);
      enter4(1, 2, 3, 4); @(negedge clk);
      check("recover_unlock", int'(bus.o_unlock), 1);
      check("recover_tries", int'(bus.tries_left), 3);
      pulse_lock();
      check("recover_relock", int'(bus.o_unlock), 0);

      // Password change
      enter4(1, 2, 3, 4); @(negedge clk);
      pulse_change();
      check("change_state", int'(bus.state_out), 3);
      check("change_unlock", int'(bus.o_unlock), 1);
      enter4(9, 8, 7, 6);
      check("change_done", int'(bus.state_out), 2);
      pulse_lock();
      enter4(1, 2, 3, 4); @(negedge clk);
      check("old_pw_fails", int'(bus.o_fail), 1);
      enter4(9, 8, 7, 6); @(negedge clk);
      check("new_pw_unlocks", int'(bus.o_unlock), 1);
      pulse_change();
      press(1); @(negedge clk);
      press(1);
      pulse_lock();
      check("abort_state", int'(bus.state_out), 0);
      enter4(9, 8, 7, 6); @(negedge clk);
      check("abort_keeps_pw", int'(bus.o_unlock), 1);
      pulse_change();
      enter4(1, 2, 3, 4);
      pulse_lock();

      // Idle timeout discards a partial entry
      press(1); @(negedge clk);
      press(2);
      repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
      check("timeout_not_yet", int'(bus.digit_count), 2);
      @(negedge clk);
      check("timeout_cleared", int'(bus.digit_count), 0);
      check("timeout_tries", int'(bus.tries_left), 3);
      enter4(1, 2, 3, 4); @(negedge clk);
      check("timeout_then_unlock", int'(bus.o_unlock), 1);
      pulse_lock();

      // Dropping on discards entry
      press(1); @(negedge clk);
      press(2); @(negedge clk);
      press(3); @(negedge clk);
      bus.on = 1'b0;
      @(negedge clk);
      bus.on = 1'b1;
      press(4);
      check("on_drop_count", int'(bus.digit_count), 1);
      check("on_drop_nounlock", int'(bus.o_unlock), 0);
      bus.on = 1'b0;
      @(negedge clk);
      bus.on = 1'b1;

      // Asynchronous reset while in CHECK
      enter4(1, 2, 3, 5); @(negedge clk);
      enter4(1, 2, 3, 4);
      #2 rst = 1'b0;
      #1;
      check("async_state", int'(bus.state_out), 0);
      check("async_unlock", int'(bus.o_unlock), 0);
      check("async_tries", int'(bus.tries_left), 3);
      check("async_count", int'(bus.digit_count), 0);
      @(negedge clk);
      rst = 1'b1;

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rate          = ((c / 500) % 2 == 1) ? 1 : 40;
         bus.on        = ($urandom_range(0, 99) != 0);
         bus.lock      = ($urandom_range(0, 99) < 2);
         bus.pw_change = ($urandom_range(0, 99) < 5);
         bus.en_key    = ($urandom_range(0, 99) < rate);
         idx           = (m_state == 3) ? m_new.size() : m_entry.size();
         if ($urandom_range(0, 3) != 0 && idx < PW_LEN)
            bus.key = 4'(m_pw[idx]);
         else
            bus.key = 4'($urandom_range(0, 15));
      end
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
